// File: rtl/ysyx_22041211_axi_arbiter.sv
// Two-master AXI-lite arbiter: IFU reads and LSU reads/writes share one SRAM slave.
// One grant at a time, held until the response handshake; LSU write > LSU read > IFU read.
module ysyx_22041211_axi_arbiter #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // IFU read (M0)
   input  logic [ADDR_LEN-1:0]   m0_ar_addr_i,
   input  logic                  m0_ar_valid_i,
   output logic                  m0_ar_ready_o,
   output logic [DATA_LEN-1:0]   m0_r_data_o,
   output logic [1:0]            m0_r_resp_o,
   output logic                  m0_r_valid_o,
   input  logic                  m0_r_ready_i,
   // LSU read (M1)
   input  logic [ADDR_LEN-1:0]   m1_ar_addr_i,
   input  logic                  m1_ar_valid_i,
   output logic                  m1_ar_ready_o,
   output logic [DATA_LEN-1:0]   m1_r_data_o,
   output logic [1:0]            m1_r_resp_o,
   output logic                  m1_r_valid_o,
   input  logic                  m1_r_ready_i,
   // LSU write (M1)
   input  logic [ADDR_LEN-1:0]   m1_aw_addr_i,
   input  logic                  m1_aw_valid_i,
   output logic                  m1_aw_ready_o,
   input  logic [DATA_LEN-1:0]   m1_w_data_i,
   input  logic [DATA_LEN/8-1:0] m1_w_strb_i,
   input  logic                  m1_w_valid_i,
   output logic                  m1_w_ready_o,
   output logic [1:0]            m1_b_resp_o,
   output logic                  m1_b_valid_o,
   input  logic                  m1_b_ready_i,
   // SRAM side
   output logic [ADDR_LEN-1:0]   s_ar_addr_o,
   output logic                  s_ar_valid_o,
   input  logic                  s_ar_ready_i,
   input  logic [DATA_LEN-1:0]   s_r_data_i,
   input  logic [1:0]            s_r_resp_i,
   input  logic                  s_r_valid_i,
   output logic                  s_r_ready_o,
   output logic [ADDR_LEN-1:0]   s_aw_addr_o,
   output logic                  s_aw_valid_o,
   input  logic                  s_aw_ready_i,
   output logic [DATA_LEN-1:0]   s_w_data_o,
   output logic [DATA_LEN/8-1:0] s_w_strb_o,
   output logic                  s_w_valid_o,
   input  logic                  s_w_ready_i,
   input  logic [1:0]            s_b_resp_i,
   input  logic                  s_b_valid_i,
   output logic                  s_b_ready_o
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] GNT_IFU_R = 2'd1;
   localparam logic [1:0] GNT_LSU_R = 2'd2;
   localparam logic [1:0] GNT_LSU_W = 2'd3;

   logic [1:0] state, state_next, grant;
   logic       ar_done, aw_done, w_done;
   logic       ifu_r, lsu_r, lsu_w;

   // Outputs decode from grant, which reads as IDLE while rst is high so nothing leaks mid-reset.
   assign grant = rst ? IDLE : state;
   assign ifu_r = (grant == GNT_IFU_R);
   assign lsu_r = (grant == GNT_LSU_R);
   assign lsu_w = (grant == GNT_LSU_W);

   // Read address: each beat is issued once per grant, then valid and ready are masked.
   assign s_ar_addr_o   = ifu_r ? m0_ar_addr_i : (lsu_r ? m1_ar_addr_i : '0);
   assign s_ar_valid_o  = ((ifu_r & m0_ar_valid_i) | (lsu_r & m1_ar_valid_i)) & ~ar_done;
   assign m0_ar_ready_o = ifu_r & s_ar_ready_i & ~ar_done;
   assign m1_ar_ready_o = lsu_r & s_ar_ready_i & ~ar_done;

   assign m0_r_data_o   = ifu_r ? s_r_data_i : '0;
   assign m0_r_resp_o   = ifu_r ? s_r_resp_i : 2'b00;
   assign m0_r_valid_o  = ifu_r & s_r_valid_i;
   assign m1_r_data_o   = lsu_r ? s_r_data_i : '0;
   assign m1_r_resp_o   = lsu_r ? s_r_resp_i : 2'b00;
   assign m1_r_valid_o  = lsu_r & s_r_valid_i;
   assign s_r_ready_o   = (ifu_r & m0_r_ready_i) | (lsu_r & m1_r_ready_i);

   // AW and W travel independently; the grant waits for B whatever their order.
   assign s_aw_addr_o   = lsu_w ? m1_aw_addr_i : '0;
   assign s_aw_valid_o  = lsu_w & m1_aw_valid_i & ~aw_done;
   assign m1_aw_ready_o = lsu_w & s_aw_ready_i & ~aw_done;
   assign s_w_data_o    = lsu_w ? m1_w_data_i : '0;
   assign s_w_strb_o    = lsu_w ? m1_w_strb_i : '0;
   assign s_w_valid_o   = lsu_w & m1_w_valid_i & ~w_done;
   assign m1_w_ready_o  = lsu_w & s_w_ready_i & ~w_done;
   assign m1_b_resp_o   = lsu_w ? s_b_resp_i : 2'b00;
   assign m1_b_valid_o  = lsu_w & s_b_valid_i;
   assign s_b_ready_o   = lsu_w & m1_b_ready_i;

   always_comb begin
      // NOTE: default assignment first so every path drives state_next and no latch is inferred.
      state_next = state;
      case (state)
         IDLE: begin
            if (m1_aw_valid_i | m1_w_valid_i) state_next = GNT_LSU_W;
            else if (m1_ar_valid_i)           state_next = GNT_LSU_R;
            else if (m0_ar_valid_i)           state_next = GNT_IFU_R;
         end
         GNT_IFU_R: if (s_r_valid_i & m0_r_ready_i) state_next = IDLE;
         GNT_LSU_R: if (s_r_valid_i & m1_r_ready_i) state_next = IDLE;
         GNT_LSU_W: if (s_b_valid_i & m1_b_ready_i) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ar_done <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == IDLE) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (s_ar_valid_o & s_ar_ready_i) ar_done <= 1'b1;
            if (s_aw_valid_o & s_aw_ready_i) aw_done <= 1'b1;
            if (s_w_valid_o & s_w_ready_i)   w_done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041211_axi_arbiter.sv
// Bench for ysyx_22041211_axi_arbiter: directed scenarios then randomized cycles,
// all checked against a grant-owner reference model.
module tb_ysyx_22041211_axi_arbiter;

   localparam int AL = 32;
   localparam int DL = 32;

   typedef enum int {O_NONE, O_IFU, O_LSU_R, O_LSU_W} owner_t;

   logic clk = 1'b0;
   logic rst;
   logic [AL-1:0] m0_ar_addr_i, m1_ar_addr_i, m1_aw_addr_i, s_ar_addr_o, s_aw_addr_o;
   logic m0_ar_valid_i, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i;
   logic m1_ar_valid_i, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i;
   logic m1_aw_valid_i, m1_aw_ready_o, m1_w_valid_i, m1_w_ready_o, m1_b_valid_o, m1_b_ready_i;
   logic [DL-1:0] m0_r_data_o, m1_r_data_o, m1_w_data_i, s_r_data_i, s_w_data_o;
   logic [1:0] m0_r_resp_o, m1_r_resp_o, m1_b_resp_o, s_r_resp_i, s_b_resp_i;
   logic [DL/8-1:0] m1_w_strb_i, s_w_strb_o;
   logic s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o;
   logic s_aw_valid_o, s_aw_ready_i, s_w_valid_o, s_w_ready_i, s_b_valid_i, s_b_ready_o;

   ysyx_22041211_axi_arbiter #(.ADDR_LEN(AL), .DATA_LEN(DL)) dut (
      .clk(clk), .rst(rst),
      .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_ready_o(m0_ar_ready_o),
      .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o), .m0_r_valid_o(m0_r_valid_o),
      .m0_r_ready_i(m0_r_ready_i),
      .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_ready_o(m1_ar_ready_o),
      .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o), .m1_r_valid_o(m1_r_valid_o),
      .m1_r_ready_i(m1_r_ready_i),
      .m1_aw_addr_i(m1_aw_addr_i), .m1_aw_valid_i(m1_aw_valid_i), .m1_aw_ready_o(m1_aw_ready_o),
      .m1_w_data_i(m1_w_data_i), .m1_w_strb_i(m1_w_strb_i), .m1_w_valid_i(m1_w_valid_i),
      .m1_w_ready_o(m1_w_ready_o),
      .m1_b_resp_o(m1_b_resp_o), .m1_b_valid_o(m1_b_valid_o), .m1_b_ready_i(m1_b_ready_i),
      .s_ar_addr_o(s_ar_addr_o), .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i),
      .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i), .s_r_valid_i(s_r_valid_i),
      .s_r_ready_o(s_r_ready_o),
      .s_aw_addr_o(s_aw_addr_o), .s_aw_valid_o(s_aw_valid_o), .s_aw_ready_i(s_aw_ready_i),
      .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o), .s_w_valid_o(s_w_valid_o),
      .s_w_ready_i(s_w_ready_i),
      .s_b_resp_i(s_b_resp_i), .s_b_valid_i(s_b_valid_i), .s_b_ready_o(s_b_ready_o)
   );

   always #5 clk = ~clk;

   logic any_out;
   assign any_out = |{m0_ar_ready_o, m0_r_data_o, m0_r_resp_o, m0_r_valid_o,
                      m1_ar_ready_o, m1_r_data_o, m1_r_resp_o, m1_r_valid_o,
                      m1_aw_ready_o, m1_w_ready_o, m1_b_resp_o, m1_b_valid_o,
                      s_ar_addr_o, s_ar_valid_o, s_r_ready_o, s_aw_addr_o, s_aw_valid_o,
                      s_w_data_o, s_w_strb_o, s_w_valid_o, s_b_ready_o};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: who owns the slave, and which beats of the grant have gone out.
   owner_t owner = O_NONE;
   bit ar_iss = 1'b0, aw_iss = 1'b0, w_iss = 1'b0;

   // Tiny slave-side memory fed from what the DUT actually forwards.
   logic [DL-1:0] mem [logic [AL-1:0]];
   logic [AL-1:0] wr_addr, rd_addr;
   logic [DL-1:0] wr_data;
   int aw_beats = 0, w_beats = 0;

   task automatic check_model();
      owner_t g;
      logic [AL:0] e_sar, e_saw;
      logic [DL+DL/8:0] e_sw;
      logic [DL+2:0] e_m0r, e_m1r;
      logic [2:0] e_b;
      logic [5:0] e_rdy;
      g = rst ? O_NONE : owner;
      e_sar = '0; e_saw = '0; e_sw = '0; e_m0r = '0; e_m1r = '0; e_b = '0; e_rdy = '0;
      case (g)
         O_IFU: begin
            e_sar = {m0_ar_addr_i, m0_ar_valid_i & ~ar_iss};
            e_m0r = {s_r_data_i, s_r_resp_i, s_r_valid_i};
            e_rdy = {s_ar_ready_i & ~ar_iss, 4'b0000, 1'b0} | {4'b0000, m0_r_ready_i, 1'b0};
         end
         O_LSU_R: begin
            e_sar = {m1_ar_addr_i, m1_ar_valid_i & ~ar_iss};
            e_m1r = {s_r_data_i, s_r_resp_i, s_r_valid_i};
            e_rdy = {1'b0, s_ar_ready_i & ~ar_iss, 2'b00, m1_r_ready_i, 1'b0};
         end
         O_LSU_W: begin
            e_saw = {m1_aw_addr_i, m1_aw_valid_i & ~aw_iss};
            e_sw  = {m1_w_data_i, m1_w_strb_i, m1_w_valid_i & ~w_iss};
            e_b   = {s_b_resp_i, s_b_valid_i};
            e_rdy = {2'b00, s_aw_ready_i & ~aw_iss, s_w_ready_i & ~w_iss, 1'b0, m1_b_ready_i};
         end
         default: ;
      endcase
      check("sar", 64'({s_ar_addr_o, s_ar_valid_o}), 64'(e_sar));
      check("saw", 64'({s_aw_addr_o, s_aw_valid_o}), 64'(e_saw));
      check("sw", 64'({s_w_data_o, s_w_strb_o, s_w_valid_o}), 64'(e_sw));
      check("m0r", 64'({m0_r_data_o, m0_r_resp_o, m0_r_valid_o}), 64'(e_m0r));
      check("m1r", 64'({m1_r_data_o, m1_r_resp_o, m1_r_valid_o}), 64'(e_m1r));
      check("m1b", 64'({m1_b_resp_o, m1_b_valid_o}), 64'(e_b));
      check("rdy", 64'({m0_ar_ready_o, m1_ar_ready_o, m1_aw_ready_o, m1_w_ready_o,
                        s_r_ready_o, s_b_ready_o}), 64'(e_rdy));
   endtask

   task automatic release_grant();
      owner = O_NONE;
      ar_iss = 1'b0; aw_iss = 1'b0; w_iss = 1'b0;
   endtask

   task automatic model_step();
      if (rst) release_grant();
      else begin
         case (owner)
            O_NONE: begin
               if (m1_aw_valid_i || m1_w_valid_i) owner = O_LSU_W;
               else if (m1_ar_valid_i)            owner = O_LSU_R;
               else if (m0_ar_valid_i)            owner = O_IFU;
            end
            O_IFU: begin
               if (m0_ar_valid_i && s_ar_ready_i) ar_iss = 1'b1;
               if (s_r_valid_i && m0_r_ready_i) release_grant();
            end
            O_LSU_R: begin
               if (m1_ar_valid_i && s_ar_ready_i) ar_iss = 1'b1;
               if (s_r_valid_i && m1_r_ready_i) release_grant();
            end
            O_LSU_W: begin
               if (m1_aw_valid_i && s_aw_ready_i) aw_iss = 1'b1;
               if (m1_w_valid_i && s_w_ready_i)   w_iss  = 1'b1;
               if (s_b_valid_i && m1_b_ready_i) release_grant();
            end
            default: ;
         endcase
      end
   endtask

   task automatic slave_track();
      if (s_aw_valid_o && s_aw_ready_i) begin wr_addr = s_aw_addr_o; aw_beats++; end
      if (s_w_valid_o && s_w_ready_i)   begin wr_data = s_w_data_o;  w_beats++;  end
      if (s_b_valid_i && s_b_ready_o)   mem[wr_addr] = wr_data;
      if (s_ar_valid_o && s_ar_ready_i) rd_addr = s_ar_addr_o;
   endtask

   // Inputs are set at the falling edge; eval samples 1 time unit later, adv crosses the rising edge.
   task automatic eval();
      #1;
      check_model();
   endtask

   task automatic adv();
      slave_track();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0;
      m0_ar_addr_i = '0; m0_ar_valid_i = 1'b0; m0_r_ready_i = 1'b0;
      m1_ar_addr_i = '0; m1_ar_valid_i = 1'b0; m1_r_ready_i = 1'b0;
      m1_aw_addr_i = '0; m1_aw_valid_i = 1'b0;
      m1_w_data_i = '0; m1_w_strb_i = '0; m1_w_valid_i = 1'b0; m1_b_ready_i = 1'b0;
      s_ar_ready_i = 1'b0; s_r_data_i = '0; s_r_resp_i = 2'b00; s_r_valid_i = 1'b0;
      s_aw_ready_i = 1'b0; s_w_ready_i = 1'b0; s_b_resp_i = 2'b00; s_b_valid_i = 1'b0;
   endtask

   initial begin
      // Reset held for two cycles with every request and ready high.
      idle_inputs();
      rst = 1'b1;
      {m0_ar_valid_i, m1_ar_valid_i, m1_aw_valid_i, m1_w_valid_i} = 4'hF;
      {m0_r_ready_i, m1_r_ready_i, m1_b_ready_i, s_ar_ready_i} = 4'hF;
      {s_r_valid_i, s_aw_ready_i, s_w_ready_i, s_b_valid_i} = 4'hF;
      m0_ar_addr_i = 32'h8000_0000;
      repeat (2) begin
         eval(); check("rst_outs", 64'(any_out), 64'd0); adv();
      end

      // Release: first cycle is still IDLE, grant follows.
      idle_inputs();
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0000;
      eval(); check("idle_after_rst", 64'(s_ar_valid_o), 64'd0); adv();
      s_ar_ready_i = 1'b1;
      eval(); check("ifu_ar_addr", 64'(s_ar_addr_o), 64'h8000_0000);
      check("ifu_ar_valid", 64'(s_ar_valid_o), 64'd1); adv();
      m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = 32'h0010_0073; m0_r_ready_i = 1'b1;
      eval(); check("ifu_r_data", 64'(m0_r_data_o), 64'h0010_0073);
      check("ifu_r_valid", 64'(m0_r_valid_o), 64'd1);
      check("ifu_m1_quiet", 64'(m1_r_valid_o), 64'd0); adv();
      idle_inputs(); eval(); adv();

      // Simultaneous IFU and LSU reads: LSU first, one IDLE cycle, then IFU.
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0004;
      m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_1000;
      eval(); adv();
      s_ar_ready_i = 1'b1;
      eval(); check("pri_lsu_addr", 64'(s_ar_addr_o), 64'h8000_1000);
      check("pri_ifu_wait", 64'(m0_ar_ready_o), 64'd0); adv();
      m1_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = 32'h1234_5678; m1_r_ready_i = 1'b1;
      eval(); check("lsu_r_data", 64'(m1_r_data_o), 64'h1234_5678);
      check("lsu_m0_quiet", 64'(m0_r_valid_o), 64'd0); adv();
      s_r_valid_i = 1'b0; m1_r_ready_i = 1'b0;
      eval(); check("gap_idle", 64'(s_ar_valid_o), 64'd0); adv();
      s_ar_ready_i = 1'b1;
      eval(); check("ifu_after_lsu", 64'({s_ar_addr_o, s_ar_valid_o}), 64'({32'h8000_0004, 1'b1}));
      adv();

      // R backpressure for three cycles: grant and data hold.
      m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = 32'hCAFE_F00D; m0_r_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         eval(); check("bp_data", 64'({m0_r_data_o, m0_r_valid_o}), 64'({32'hCAFE_F00D, 1'b1}));
         adv();
      end
      m0_r_ready_i = 1'b1;
      eval(); check("bp_release", 64'(s_r_ready_o), 64'd1); adv();
      idle_inputs(); eval(); adv();

      // LSU write with W two cycles ahead of AW.
      aw_beats = 0; w_beats = 0;
      m1_w_valid_i = 1'b1; m1_w_data_i = 32'hDEAD_BEEF; m1_w_strb_i = 4'hF;
      eval(); check("w_idle", 64'(s_w_valid_o), 64'd0); adv();
      s_w_ready_i = 1'b1;
      eval(); check("w_fwd", 64'({s_w_data_o, s_w_strb_o, s_w_valid_o}),
                    64'({32'hDEAD_BEEF, 4'hF, 1'b1})); adv();
      m1_aw_valid_i = 1'b1; m1_aw_addr_i = 32'h8000_2000; s_aw_ready_i = 1'b1;
      eval(); check("w_once", 64'(s_w_valid_o), 64'd0);
      check("aw_fwd", 64'({s_aw_addr_o, s_aw_valid_o}), 64'({32'h8000_2000, 1'b1})); adv();
      m1_w_valid_i = 1'b0; m1_aw_valid_i = 1'b0; s_w_ready_i = 1'b0; s_aw_ready_i = 1'b0;
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0008;
      eval(); check("w_hold", 64'(s_ar_valid_o), 64'd0); adv();
      m0_ar_valid_i = 1'b0; s_b_valid_i = 1'b1; s_b_resp_i = 2'b00; m1_b_ready_i = 1'b1;
      eval(); check("b_fwd", 64'({m1_b_resp_o, m1_b_valid_o}), 64'({2'b00, 1'b1})); adv();
      idle_inputs(); eval(); adv();
      check("aw_beats", 64'(aw_beats), 64'd1);
      check("w_beats", 64'(w_beats), 64'd1);

      // Read back through the arbiter from the slave memory.
      m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_2000;
      eval(); adv();
      s_ar_ready_i = 1'b1; eval(); adv();
      m1_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = mem[rd_addr]; m1_r_ready_i = 1'b1;
      eval(); check("readback", 64'(m1_r_data_o), 64'hDEAD_BEEF); adv();

      // Stray responses in IDLE are dropped.
      idle_inputs();
      s_r_valid_i = 1'b1; s_b_valid_i = 1'b1;
      m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1; m1_b_ready_i = 1'b1;
      eval(); check("stray_r", 64'({m0_r_valid_o, m1_r_valid_o, m1_b_valid_o}), 64'd0); adv();

      // Reset after the AW handshake, before B.
      idle_inputs();
      m1_aw_valid_i = 1'b1; m1_aw_addr_i = 32'h8000_3000;
      eval(); adv();
      s_aw_ready_i = 1'b1; eval(); adv();
      m1_aw_valid_i = 1'b0; s_aw_ready_i = 1'b0; rst = 1'b1;
      eval(); check("rst_mid_outs", 64'(any_out), 64'd0); adv();
      rst = 1'b0; s_b_valid_i = 1'b1;
      eval(); check("rst_mid_idle", 64'(any_out), 64'd0); adv();
      idle_inputs();
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0010;
      eval(); adv();
      s_ar_ready_i = 1'b1;
      eval(); check("post_rst_ar", 64'(s_ar_addr_o), 64'h8000_0010); adv();
      m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = 32'h0000_0013; m0_r_ready_i = 1'b1;
      eval(); check("post_rst_r", 64'(m0_r_data_o), 64'h0000_0013); adv();
      idle_inputs(); eval(); adv();

      // Randomized cycles, including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) == 0);
         m0_ar_valid_i = ($urandom_range(0, 2) == 0);
         m1_ar_valid_i = ($urandom_range(0, 3) == 0);
         m1_aw_valid_i = ($urandom_range(0, 4) == 0);
         m1_w_valid_i  = ($urandom_range(0, 4) == 0);
         m0_ar_addr_i  = $urandom;
         m1_ar_addr_i  = $urandom;
         m1_aw_addr_i  = $urandom;
         m1_w_data_i   = $urandom;
         m1_w_strb_i   = 4'($urandom_range(0, 15));
         m0_r_ready_i  = ($urandom_range(0, 1) == 0);
         m1_r_ready_i  = ($urandom_range(0, 1) == 0);
         m1_b_ready_i  = ($urandom_range(0, 1) == 0);
         s_ar_ready_i  = ($urandom_range(0, 1) == 0);
         s_aw_ready_i  = ($urandom_range(0, 1) == 0);
         s_w_ready_i   = ($urandom_range(0, 1) == 0);
         s_r_valid_i   = ($urandom_range(0, 2) == 0);
         s_b_valid_i   = ($urandom_range(0, 2) == 0);
         s_r_data_i    = $urandom;
         s_r_resp_i    = 2'($urandom_range(0, 3));
         s_b_resp_i    = 2'($urandom_range(0, 3));
         eval();
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22041211_axi_arbiter.md
# ysyx_22041211_axi_arbiter

Two-master, one-slave AXI-lite arbiter that lets the IFU fetch port and the LSU data port share a single `ysyx_22041211_AXI_SRAM` instance. It sits between `ysyx_22041211_cpu` and the memory in the top level and replaces the separate instruction and data SRAMs. One transaction is granted at a time and held until its response handshake completes. LSU has fixed priority over IFU.

## Interface
- `ADDR_LEN`, default 32: address width.
- `DATA_LEN`, default 32: data width; strobe width is `DATA_LEN/8`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- IFU read slave side (M0):
  - `m0_ar_addr_i` in ADDR_LEN, `m0_ar_valid_i` in 1, `m0_ar_ready_o` out 1.
  - `m0_r_data_o` out DATA_LEN, `m0_r_resp_o` out 2, `m0_r_valid_o` out 1, `m0_r_ready_i` in 1.
- LSU read slave side (M1):
  - `m1_ar_addr_i` in ADDR_LEN, `m1_ar_valid_i` in 1, `m1_ar_ready_o` out 1.
  - `m1_r_data_o` out DATA_LEN, `m1_r_resp_o` out 2, `m1_r_valid_o` out 1, `m1_r_ready_i` in 1.
- LSU write slave side (M1):
  - `m1_aw_addr_i` in ADDR_LEN, `m1_aw_valid_i` in 1, `m1_aw_ready_o` out 1.
  - `m1_w_data_i` in DATA_LEN, `m1_w_strb_i` in DATA_LEN/8, `m1_w_valid_i` in 1, `m1_w_ready_o` out 1.
  - `m1_b_resp_o` out 2, `m1_b_valid_o` out 1, `m1_b_ready_i` in 1.
- SRAM master side, one port for each AXI-lite channel:
  - `s_ar_addr_o`, `s_ar_valid_o`, `s_ar_ready_i`.
  - `s_r_data_i`, `s_r_resp_i`, `s_r_valid_i`, `s_r_ready_o`.
  - `s_aw_addr_o`, `s_aw_valid_o`, `s_aw_ready_i`.
  - `s_w_data_o`, `s_w_strb_o`, `s_w_valid_o`, `s_w_ready_i`.
  - `s_b_resp_i`, `s_b_valid_i`, `s_b_ready_o`.
  - Widths match the corresponding master ports.

## Operation
State register, 2 bits. States are IDLE, GNT_IFU_R, GNT_LSU_R and GNT_LSU_W.

Transitions out of IDLE:
- To GNT_LSU_W if `m1_aw_valid_i | m1_w_valid_i`.
- Otherwise to GNT_LSU_R if `m1_ar_valid_i`.
- Otherwise to GNT_IFU_R if `m0_ar_valid_i`.
- Otherwise stay in IDLE.
- Priority when several requests are present: LSU write > LSU read > IFU read.

Transitions back to IDLE:
- GNT_IFU_R → IDLE on `s_r_valid_i & m0_r_ready_i`.
- GNT_LSU_R → IDLE on `s_r_valid_i & m1_r_ready_i`.
- GNT_LSU_W → IDLE on `s_b_valid_i & m1_b_ready_i`.

Channel gating (combinational from state):
- Every channel of the granted master is passed straight through to the slave, in both directions.
- Every channel of an ungranted master is cut off:
  - valid and ready outputs toward it are 0;
  - data/resp outputs toward it are 0.
- In IDLE:
  - all `s_*_valid_o` and `s_*_ready_o` are 0;
  - the addr/data/strb outputs are 0.
- A stray `s_r_valid_i` or `s_b_valid_i` in IDLE, or on the channel not owned by the current grant, is ignored and not forwarded.

Write grant:
- AW and W are forwarded independently.
- The grant is held until the B handshake, whatever order the AW and W handshakes occur in.

Address accept flags:
- `ar_done`: set on the AR handshake while granted.
- `aw_done`: set on the AW handshake while granted.
- `w_done`: set on the W handshake while granted.
- All three clear on return to IDLE.
- While a flag is set, the matching `s_*_valid_o` is forced to 0, so each address/data beat is issued exactly once per grant.

Master behaviour:
- A master's request persists while it is ungranted; the arbiter does not latch requests.
- A master that drops valid while ungranted simply loses its request.

Reset: `rst` high at a rising edge forces the following, regardless of any transaction in flight:
- state = IDLE;
- all done flags = 0;
- all outputs = 0.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives the grant state after edge N. The slave sees valid in that same cycle, with no registered stage on the address.
- Payload timing: data, resp and ready pass combinationally in the granted state, so SRAM read latency is preserved unchanged.
- Completion: the response handshake at edge M returns the state to IDLE after M. The minimum gap between two grants is therefore 1 IDLE cycle.
- Requests present during a grant are evaluated only in IDLE. Back-to-back LSU requests therefore starve the IFU; this is accepted because the CPU issues at most one outstanding memory operation at a time.
- A response handshake in the same cycle as the address handshake (zero-latency slave) is legal. The grant ends after that edge.

## Test plan
- Reset, then idle:
  - Hold `rst`=1 for 2 cycles with all valids=1.
  - Required: every output is 0 during reset.
  - First cycle after release with `m0_ar_valid_i`=1 only: state IDLE, `s_ar_valid_o`=0.
  - Following cycle: `s_ar_addr_o`=M0 address.
- IFU fetch:
  - `m0_ar_addr_i`=0x80000000.
  - Required: `s_ar_addr_o`=0x80000000.
  - SRAM returns 0x00100073.
  - Required: `m0_r_data_o`=0x00100073 with `m0_r_valid_o`=1; `m1_r_valid_o` stays 0.
- Simultaneous IFU read (0x80000004) and LSU read (0x80001000) in the same cycle:
  - Required: the LSU is granted first and `s_ar_addr_o`=0x80001000.
  - After the LSU R handshake, 1 IDLE cycle, then the IFU grant with address 0x80000004.
- LSU write, W before AW:
  - W data 0xDEADBEEF with strb 0xF, AW address 0x80002000 two cycles later.
  - Required: each beat is forwarded once; the grant is held until B.
  - Required: `m1_b_valid_o`=1 with resp 0.
  - A later LSU read of 0x80002000 returns 0xDEADBEEF.
- Stray/backpressure:
  - Force `s_r_valid_i`=1 while in IDLE.
  - Required: `m0_r_valid_o`=`m1_r_valid_o`=0.
  - With `m0_r_ready_i`=0 for 3 cycles while granted: the grant is held and the R data stays stable.
- Reset mid-write:
  - Assert `rst` after the AW handshake but before B.
  - Required: state IDLE next cycle, all outputs 0.
  - A fresh IFU read then completes normally.
